// File: rtl/tiled_matmul_sequencer.sv
// Command sequencer that tiles an MxK * KxN product onto an ARR x ARR systolic array:
// register-file read strobes, array framing, drain wait and masked tile-row write-back.
module tiled_matmul_sequencer #(
  parameter int ARR    = 8,
  parameter int DIM_W  = 6,
  parameter int PAGE_W = 4,
  parameter int LAT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PAGE_W-1:0] cmd_x_page,
  input  logic [PAGE_W-1:0] cmd_w_page,
  input  logic [PAGE_W-1:0] cmd_y_page,
  input  logic [DIM_W-1:0]  cmd_m,
  input  logic [DIM_W-1:0]  cmd_k,
  input  logic [DIM_W-1:0]  cmd_n,
  input  logic [2:0]        cmd_cfg,
  output logic              rd_en,
  output logic [PAGE_W-1:0] x_page,
  output logic [PAGE_W-1:0] w_page,
  output logic [DIM_W-1:0]  x_tile,
  output logic [DIM_W-1:0]  w_tile,
  output logic [DIM_W-1:0]  rd_k,
  output logic              arr_first,
  output logic              arr_last,
  output logic              y_wr_en,
  output logic [PAGE_W-1:0] y_page,
  output logic [DIM_W-1:0]  y_row,
  output logic [DIM_W-1:0]  y_col_tile,
  output logic [ARR-1:0]    y_col_mask,
  output logic              y_acc,
  output logic              cfg_relu,
  output logic              cfg_transpose,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int W1    = DIM_W + 1;
  localparam int CNT_W = (W1 > $clog2(LAT + 1)) ? W1 : $clog2(LAT + 1);
  localparam logic [W1-1:0] ARR_W = W1'(ARR);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PAGE_W-1:0] x_page_q, x_page_d, w_page_q, w_page_d, y_page_q, y_page_d;
  logic [DIM_W-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
  logic [2:0]        cfg_q, cfg_d;
  logic [DIM_W-1:0]  ti_q, ti_d, tj_q, tj_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [W1-1:0] row_base, col_base, rows_left, cols_left, rows_this, cols_this;
  logic          last_i, last_j, k_last, drain_last, row_last, zero_dim;

  // Remaining rows/columns are measured from the current tile origin in DIM_W+1 bits.
  assign row_base   = W1'(ti_q) * ARR_W;
  assign col_base   = W1'(tj_q) * ARR_W;
  assign rows_left  = W1'(m_q) - row_base;
  assign cols_left  = W1'(n_q) - col_base;
  assign rows_this  = (rows_left < ARR_W) ? rows_left : ARR_W;
  assign cols_this  = (cols_left < ARR_W) ? cols_left : ARR_W;
  assign last_i     = (rows_left <= ARR_W);
  assign last_j     = (cols_left <= ARR_W);
  assign k_last     = (cnt_q == CNT_W'(k_q - 1'b1));
  assign drain_last = (cnt_q == CNT_W'(LAT - 1));
  assign row_last   = (cnt_q == CNT_W'(rows_this - 1'b1));
  assign zero_dim   = (cmd_m == '0) || (cmd_k == '0) || (cmd_n == '0);

  assign cmd_ready     = enable && (state_q == S_IDLE);
  assign rd_en         = enable && (state_q == S_FEED);
  assign arr_first     = rd_en && (cnt_q == '0);
  assign arr_last      = rd_en && k_last;
  assign y_wr_en       = enable && (state_q == S_WRITE);
  assign done          = enable && (state_q == S_DONE);
  assign err           = enable && err_q;
  assign busy          = (state_q != S_IDLE);
  assign x_page        = x_page_q;
  assign w_page        = w_page_q;
  assign y_page        = y_page_q;
  assign x_tile        = ti_q;
  assign w_tile        = tj_q;
  assign rd_k          = cnt_q[DIM_W-1:0];
  assign y_row         = DIM_W'(row_base + W1'(cnt_q));
  assign y_col_tile    = tj_q;
  assign y_acc         = cfg_q[2];
  assign cfg_relu      = cfg_q[1];
  assign cfg_transpose = cfg_q[0];

  always_comb begin
    y_col_mask = '0;
    for (int c = 0; c < ARR; c++) begin
      y_col_mask[c] = (W1'(c) < cols_this);
    end
  end

  // Everything holds while enable is low; the err pulse is simply dropped.
  always_comb begin
    state_d  = state_q;
    x_page_d = x_page_q;
    w_page_d = w_page_q;
    y_page_d = y_page_q;
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    cfg_d    = cfg_q;
    ti_d     = ti_q;
    tj_d     = tj_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            x_page_d = cmd_x_page;
            w_page_d = cmd_w_page;
            y_page_d = cmd_y_page;
            m_d      = cmd_m;
            k_d      = cmd_k;
            n_d      = cmd_n;
            cfg_d    = cmd_cfg;
            ti_d     = '0;
            tj_d     = '0;
            cnt_d    = '0;
            if (zero_dim) err_d = 1'b1;
            else          state_d = S_FEED;
          end
        end
        S_FEED: begin
          if (k_last) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_last) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (row_last) begin
            cnt_d = '0;
            // Column tiles are the inner loop; wrap j before stepping i.
            if (!last_j) begin
              tj_d    = tj_q + 1'b1;
              state_d = S_FEED;
            end else if (!last_i) begin
              tj_d    = '0;
              ti_d    = ti_q + 1'b1;
              state_d = S_FEED;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_page_q <= '0;
      w_page_q <= '0;
      y_page_q <= '0;
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      cfg_q    <= '0;
      ti_q     <= '0;
      tj_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_page_q <= x_page_d;
      w_page_q <= w_page_d;
      y_page_q <= y_page_d;
      m_q      <= m_d;
      k_q      <= k_d;
      n_q      <= n_d;
      cfg_q    <= cfg_d;
      ti_q     <= ti_d;
      tj_q     <= tj_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_tiled_matmul_sequencer.sv
// Scoreboard bench for tiled_matmul_sequencer: a tile-loop model queues expected read and
// write events with their cycles; a negedge monitor pops and compares them as they appear.
module tb_tiled_matmul_sequencer;

  localparam int ARR    = 8;
  localparam int DIM_W  = 6;
  localparam int PAGE_W = 4;
  localparam int LAT    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [PAGE_W-1:0] cmd_x_page = '0, cmd_w_page = '0, cmd_y_page = '0;
  logic [DIM_W-1:0]  cmd_m = '0, cmd_k = '0, cmd_n = '0;
  logic [2:0]        cmd_cfg = '0;
  logic              rd_en, arr_first, arr_last, y_wr_en, y_acc, cfg_relu, cfg_transpose;
  logic              busy, done, err;
  logic [PAGE_W-1:0] x_page, w_page, y_page;
  logic [DIM_W-1:0]  x_tile, w_tile, rd_k, y_row, y_col_tile;
  logic [ARR-1:0]    y_col_mask;
  logic [59:0]       all_outs;

  tiled_matmul_sequencer #(.ARR(ARR), .DIM_W(DIM_W), .PAGE_W(PAGE_W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x_page(cmd_x_page), .cmd_w_page(cmd_w_page), .cmd_y_page(cmd_y_page),
    .cmd_m(cmd_m), .cmd_k(cmd_k), .cmd_n(cmd_n), .cmd_cfg(cmd_cfg),
    .rd_en(rd_en), .x_page(x_page), .w_page(w_page), .x_tile(x_tile), .w_tile(w_tile),
    .rd_k(rd_k), .arr_first(arr_first), .arr_last(arr_last), .y_wr_en(y_wr_en),
    .y_page(y_page), .y_row(y_row), .y_col_tile(y_col_tile), .y_col_mask(y_col_mask),
    .y_acc(y_acc), .cfg_relu(cfg_relu), .cfg_transpose(cfg_transpose),
    .busy(busy), .done(done), .err(err)
  );

  assign all_outs = {rd_en, arr_first, arr_last, y_wr_en, y_acc, cfg_relu, cfg_transpose,
                     busy, done, err, x_page, w_page, y_page, x_tile, w_tile, rd_k,
                     y_row, y_col_tile, y_col_mask};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic [DIM_W-1:0] k;
    logic             first;
    logic             last;
    logic [DIM_W-1:0] ti;
    logic [DIM_W-1:0] tj;
  } rd_exp_t;

  typedef struct {
    int               cyc;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] ct;
    logic [ARR-1:0]   mask;
    logic             acc;
  } wr_exp_t;

  rd_exp_t           rd_q[$];
  wr_exp_t           wr_q[$];
  rd_exp_t           mre;
  wr_exp_t           mwe;
  int                total = 0;
  int                bad = 0;
  int                done_cyc = -1;
  int                done_exp = 0;
  int                stall_from = 32'h3fff_ffff;
  int                stall_len = 0;
  int                ecyc;
  int                wr_seen = 0;
  int                last_row_seen = -1;
  logic [DIM_W-1:0]  held_k = '0;
  logic [PAGE_W-1:0] exp_x = '0, exp_w = '0, exp_y = '0;

  // Monitor: pops one expectation per observed strobe; stall cycles shift later events.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_en) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL rd_extra: read at cycle %0d k=%0d, required none", cyc, rd_k);
        end else begin
          mre  = rd_q.pop_front();
          ecyc = mre.cyc + ((mre.cyc >= stall_from) ? stall_len : 0);
          if ({cyc, rd_k, arr_first, arr_last, x_tile, w_tile, x_page, w_page} !==
              {ecyc, mre.k, mre.first, mre.last, mre.ti, mre.tj, exp_x, exp_w}) begin
            bad++;
            $display("[TB] FAIL rd_event: got cyc=%0d k=%0d first=%0b last=%0b ti=%0d tj=%0d xp=%0d wp=%0d, required cyc=%0d k=%0d first=%0b last=%0b ti=%0d tj=%0d xp=%0d wp=%0d",
                     cyc, rd_k, arr_first, arr_last, x_tile, w_tile, x_page, w_page,
                     ecyc, mre.k, mre.first, mre.last, mre.ti, mre.tj, exp_x, exp_w);
          end
        end
      end else if (arr_first || arr_last) begin
        total++;
        bad++;
        $display("[TB] FAIL framing_no_rd: cycle %0d first=%0b last=%0b, required 0 0", cyc, arr_first, arr_last);
      end
      if (y_wr_en) begin
        total++;
        wr_seen++;
        last_row_seen = int'(y_row);
        if (wr_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL wr_extra: write at cycle %0d row=%0d, required none", cyc, y_row);
        end else begin
          mwe  = wr_q.pop_front();
          ecyc = mwe.cyc + ((mwe.cyc >= stall_from) ? stall_len : 0);
          if ({cyc, y_row, y_col_tile, y_col_mask, y_acc, y_page} !==
              {ecyc, mwe.row, mwe.ct, mwe.mask, mwe.acc, exp_y}) begin
            bad++;
            $display("[TB] FAIL wr_event: got cyc=%0d row=%0d tile=%0d mask=%h acc=%0b yp=%0d, required cyc=%0d row=%0d tile=%0d mask=%h acc=%0b yp=%0d",
                     cyc, y_row, y_col_tile, y_col_mask, y_acc, y_page,
                     ecyc, mwe.row, mwe.ct, mwe.mask, mwe.acc, exp_y);
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL busy_at_done: got %b, required 1", busy);
        end
      end
      if (!enable) begin
        total++;
        if ({rd_en, arr_first, arr_last, y_wr_en, done, err, cmd_ready} !== 7'b0 || rd_k !== held_k) begin
          bad++;
          $display("[TB] FAIL stall_outputs: got strobes=%b rd_k=%0d, required 0000000 rd_k=%0d",
                   {rd_en, arr_first, arr_last, y_wr_en, done, err, cmd_ready}, rd_k, held_k);
        end
      end
    end
  end

  // Independent tile-loop model: walks i outer, j inner and queues every expected event.
  task automatic model_cmd(input int t, input int m, input int k, input int n, input logic acc);
    int c, r_cnt, c_cnt;
    rd_exp_t re;
    wr_exp_t we;
    c = t + 1;
    for (int i = 0; i * ARR < m; i++) begin
      for (int j = 0; j * ARR < n; j++) begin
        for (int kk = 0; kk < k; kk++) begin
          re.cyc   = c + kk;
          re.k     = DIM_W'(kk);
          re.first = (kk == 0);
          re.last  = (kk == k - 1);
          re.ti    = DIM_W'(i);
          re.tj    = DIM_W'(j);
          rd_q.push_back(re);
        end
        c += k + LAT;
        r_cnt = (m - i * ARR < ARR) ? m - i * ARR : ARR;
        c_cnt = (n - j * ARR < ARR) ? n - j * ARR : ARR;
        for (int r = 0; r < r_cnt; r++) begin
          we.cyc  = c + r;
          we.row  = DIM_W'(i * ARR + r);
          we.ct   = DIM_W'(j);
          we.mask = ARR'((1 << c_cnt) - 1);
          we.acc  = acc;
          wr_q.push_back(we);
        end
        c += r_cnt;
      end
    end
    done_exp = c;
  endtask

  task automatic scramble_fields();
    cmd_x_page = PAGE_W'($urandom);
    cmd_w_page = PAGE_W'($urandom);
    cmd_y_page = PAGE_W'($urandom);
    cmd_m      = DIM_W'($urandom_range(1, 63));
    cmd_k      = DIM_W'($urandom_range(1, 63));
    cmd_n      = DIM_W'($urandom_range(1, 63));
    cmd_cfg    = 3'($urandom);
  endtask

  task automatic run_cmd(input int m, input int k, input int n, input logic [2:0] cfg,
                         input int hold_valid, input int stall_at, input int stall_n,
                         output int t_acc);
    int rel;
    @(posedge clk); #1;
    scramble_fields();
    cmd_m = DIM_W'(m);
    cmd_k = DIM_W'(k);
    cmd_n = DIM_W'(n);
    cmd_cfg = cfg;
    exp_x = cmd_x_page;
    exp_w = cmd_w_page;
    exp_y = cmd_y_page;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept_ready: got %b, required 1", cmd_ready);
    end
    t_acc = cyc;
    done_cyc = -1;
    wr_seen = 0;
    if (stall_n > 0) begin
      stall_from = t_acc + stall_at;
      stall_len  = stall_n;
      held_k     = DIM_W'(stall_at - 1);
    end
    model_cmd(t_acc, m, k, n, cfg[2]);
    for (int w = 0; w < 3000 && done_cyc < 0; w++) begin
      @(posedge clk); #1;
      rel = cyc - t_acc;
      scramble_fields();
      if (rel <= hold_valid) begin
        cmd_valid = 1'b1;
        total++;
        if (cmd_ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL ready_while_busy: got %b, required 0", cmd_ready);
        end
      end else begin
        cmd_valid = 1'b0;
      end
      if (stall_n > 0 && rel == stall_at) enable = 1'b0;
      if (stall_n > 0 && rel == stall_at + stall_n) enable = 1'b1;
    end
    cmd_valid = 1'b0;
    enable = 1'b1;
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("[TB] FAIL done_timeout: no done, required at cycle %0d", done_exp);
      rd_q.delete();
      wr_q.delete();
    end else if (done_cyc !== done_exp + stall_n) begin
      bad++;
      $display("[TB] FAIL done_cycle: got %0d, required %0d", done_cyc, done_exp + stall_n);
    end
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL pending_events: got rd=%0d wr=%0d left, required 0 0", rd_q.size(), wr_q.size());
    end
    total++;
    if ({busy, cmd_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL idle_after_done: got busy=%b ready=%b, required 0 1", busy, cmd_ready);
    end
    stall_from = 32'h3fff_ffff;
    stall_len  = 0;
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (all_outs !== 60'd0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got outs=%h ready=%b, required 0 1", all_outs, cmd_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_8x8();
    int t;
    run_cmd(8, 8, 8, 3'b000, 0, 0, 0, t);
    total++;
    if (done_cyc - t !== 33) begin
      bad++;
      $display("[TB] FAIL done_latency_8x8: got %0d, required 33", done_cyc - t);
    end
  endtask

  task automatic test_nonsquare();
    int t;
    run_cmd(10, 5, 12, 3'b011, 0, 0, 0, t);
    total++;
    if ({wr_seen, last_row_seen, done_cyc - t} !== {32'd20, 32'd9, 32'd105}) begin
      bad++;
      $display("[TB] FAIL nonsquare_summary: got writes=%0d last_row=%0d latency=%0d, required 20 9 105",
               wr_seen, last_row_seen, done_cyc - t);
    end
    total++;
    if ({cfg_relu, cfg_transpose, y_acc} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL cfg_latched: got relu/trans/acc=%b, required 110", {cfg_relu, cfg_transpose, y_acc});
    end
  endtask

  task automatic test_k1();
    int t;
    run_cmd(3, 1, 20, 3'b100, 0, 0, 0, t);
    total++;
    if ({cfg_relu, y_acc, done_cyc - t} !== {1'b0, 1'b1, 32'd61}) begin
      bad++;
      $display("[TB] FAIL k1_summary: got relu=%b acc=%b latency=%0d, required 0 1 61", cfg_relu, y_acc, done_cyc - t);
    end
  endtask

  task automatic test_err();
    int t;
    @(posedge clk); #1;
    cmd_m = 6'd5;
    cmd_k = 6'd5;
    cmd_n = 6'd0;
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL err_accept_ready: got %b, required 1", cmd_ready);
    end
    t = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    total++;
    if ({err, busy, cmd_ready, cyc - t} !== {1'b1, 1'b0, 1'b1, 32'd1}) begin
      bad++;
      $display("[TB] FAIL err_pulse: got err=%b busy=%b ready=%b, required 1 0 1", err, busy, cmd_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({err, busy, cmd_ready} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL err_after: got err=%b busy=%b ready=%b, required 0 0 1", err, busy, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(posedge clk); #1;
    scramble_fields();
    cmd_m = 6'd8;
    cmd_k = 6'd8;
    cmd_n = 6'd8;
    cmd_cfg = 3'b000;
    exp_x = cmd_x_page;
    exp_w = cmd_w_page;
    exp_y = cmd_y_page;
    cmd_valid = 1'b1;
    t = cyc;
    done_cyc = -1;
    model_cmd(t, 8, 8, 8, 1'b0);
    for (int w = 0; w < 100 && cyc < t + 12; w++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    total++;
    if ({busy, rd_q.size()} !== {1'b1, 32'd0}) begin
      bad++;
      $display("[TB] FAIL drain_reached: got busy=%b reads_left=%0d, required 1 0", busy, rd_q.size());
    end
    reset = 1'b1;
    wr_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (all_outs !== 60'd0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_outputs: got outs=%h ready=%b, required 0 1", all_outs, cmd_ready);
    end
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (done_cyc !== -1) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got done at %0d, required none", done_cyc);
    end
    run_cmd(8, 8, 8, 3'b001, 0, 0, 0, t);
    total++;
    if (done_cyc - t !== 33) begin
      bad++;
      $display("[TB] FAIL done_latency_after_abort: got %0d, required 33", done_cyc - t);
    end
  endtask

  task automatic test_busy_ignore();
    int t;
    run_cmd(8, 8, 8, 3'b010, 6, 0, 0, t);
    total++;
    if (done_cyc - t !== 33) begin
      bad++;
      $display("[TB] FAIL done_latency_ignore: got %0d, required 33", done_cyc - t);
    end
  endtask

  task automatic test_stall();
    int t;
    run_cmd(8, 8, 8, 3'b000, 0, 4, 3, t);
    total++;
    if (done_cyc - t !== 36) begin
      bad++;
      $display("[TB] FAIL done_latency_stall: got %0d, required 36", done_cyc - t);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    run_cmd(17, 2, 9, 3'b001, 0, 0, 0, t);
    run_cmd(63, 2, 63, 3'b100, 0, 0, 0, t);
    total++;
    if ({wr_seen, last_row_seen} !== {32'd504, 32'd62}) begin
      bad++;
      $display("[TB] FAIL max_dims_writes: got writes=%0d last_row=%0d, required 504 62", wr_seen, last_row_seen);
    end
  endtask

  initial begin
    test_reset();
    test_8x8();
    test_nonsquare();
    test_k1();
    test_err();
    test_reset_mid();
    test_busy_ignore();
    test_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
